// File: rtl/pipe_collision_score.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_collision_score
//  Purpose  : Game-state controller for a side-scrolling pipe game. Detects
//             bird/pipe/floor collisions once per frame, keeps a 3-digit BCD
//             score, and sequences IDLE -> PLAY -> DEAD -> IDLE.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1   system clock, rising edge
//    RESET_N      in   1   synchronous active-low reset
//    move         in   1   frame tick from pipe generator (asynchronous, slow)
//    flap         in   1   player button, debounced level
//    bird_y       in  11   bird top edge
//    pipe_x       in  11   pipe left edge
//    pipe_y       in  11   pipe gap centre
//    playing      out  1   high in PLAY
//    game_over    out  1   high in DEAD
//    hit_pulse    out  1   one-clk pulse on the collision entering DEAD
//    score_bcd    out 12   score, three BCD digits, [11:8] hundreds
//    hiscore_bcd  out 12   best score (only with PIPE_COLLISION_HISCORE_EN)
//  Configuration
//    PIPE_COLLISION_HISCORE_EN : when defined, adds the hiscore_bcd register
//                                and port.
// ============================================================================
module pipe_collision_score #(
   parameter logic [10:0] BIRD_X      = 11'd200,
   parameter logic [10:0] BIRD_W      = 11'd32,
   parameter logic [10:0] BIRD_H      = 11'd24,
   parameter logic [10:0] PIPE_W      = 11'd60,
   parameter logic [10:0] GAP_H       = 11'd150,
   parameter logic [10:0] FLOOR_Y     = 11'd600,
   parameter logic [5:0]  DEAD_FRAMES = 6'd32
) (
   input  logic        clk,
   input  logic        RESET_N,
   input  logic        move,
   input  logic        flap,
   input  logic [10:0] bird_y,
   input  logic [10:0] pipe_x,
   input  logic [10:0] pipe_y,
   output logic        playing,
   output logic        game_over,
   output logic        hit_pulse,
   output logic [11:0] score_bcd
`ifdef PIPE_COLLISION_HISCORE_EN
   ,
   output logic [11:0] hiscore_bcd
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_mv_s1;
   logic        r_mv_s2;
   logic        r_mv_s3;
   logic        w_frame_tk;

   logic [10:0] r_prev_x;
   logic        r_scored;
   logic        w_scored_nxt;
   logic [5:0]  r_dead_cnt;
   logic [5:0]  w_dead_cnt_nxt;
   logic [11:0] r_score;
   logic [11:0] w_score_nxt;
   logic [11:0] w_score_inc;
   logic        r_playing;
   logic        r_game_over;
   logic        r_hit_pulse;
   logic        w_enter_dead;

   // ------------------------------------------------------------------------
   // move synchroniser; the third flop only serves edge detection
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!RESET_N) begin
         r_mv_s1 <= 1'b0;
         r_mv_s2 <= 1'b0;
         r_mv_s3 <= 1'b0;
      end else begin
         r_mv_s1 <= move;
         r_mv_s2 <= r_mv_s1;
         r_mv_s3 <= r_mv_s2;
      end
   end

   assign w_frame_tk = r_mv_s2 & ~r_mv_s3;

   // ------------------------------------------------------------------------
   // Collision geometry, all in 12 bits so sums near 2047 cannot wrap
   // ------------------------------------------------------------------------
   logic [11:0] w_bird_l, w_bird_r, w_bird_t, w_bird_b;
   logic [11:0] w_pipe_l, w_pipe_r, w_pipe_c, w_half_gap;
   logic [11:0] w_gap_top, w_gap_bot;
   logic        w_h_ovl, w_v_out, w_floor, w_hit, w_passed, w_wrapped;

   assign w_bird_l   = {1'b0, BIRD_X};
   assign w_bird_r   = {1'b0, BIRD_X} + {1'b0, BIRD_W};
   assign w_bird_t   = {1'b0, bird_y};
   assign w_bird_b   = {1'b0, bird_y} + {1'b0, BIRD_H};
   assign w_pipe_l   = {1'b0, pipe_x};
   assign w_pipe_r   = {1'b0, pipe_x} + {1'b0, PIPE_W};
   assign w_pipe_c   = {1'b0, pipe_y};
   assign w_half_gap = {2'b00, GAP_H[10:1]};

   // Gap top is clamped at zero when the gap reaches above the screen
   assign w_gap_top  = (w_pipe_c < w_half_gap) ? 12'd0 : (w_pipe_c - w_half_gap);
   assign w_gap_bot  = w_pipe_c + w_half_gap;

   assign w_h_ovl    = (w_bird_r > w_pipe_l) && (w_bird_l < w_pipe_r);
   assign w_v_out    = (w_bird_t < w_gap_top) || (w_bird_b > w_gap_bot);
   assign w_floor    = (w_bird_b >= {1'b0, FLOOR_Y});
   assign w_hit      = (w_h_ovl && w_v_out) || w_floor;
   assign w_passed   = (w_pipe_r < w_bird_l);
   assign w_wrapped  = (pipe_x > r_prev_x);

   // ------------------------------------------------------------------------
   // Saturating BCD increment
   // ------------------------------------------------------------------------
   always_comb begin
      w_score_inc = r_score;
      if (r_score == 12'h999) begin
         w_score_inc = r_score;
      end else if (r_score[3:0] != 4'd9) begin
         w_score_inc = {r_score[11:4], r_score[3:0] + 4'd1};
      end else if (r_score[7:4] != 4'd9) begin
         w_score_inc = {r_score[11:8], r_score[7:4] + 4'd1, 4'd0};
      end else begin
         w_score_inc = {r_score[11:8] + 4'd1, 8'h00};
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state and datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_score_nxt    = r_score;
      w_scored_nxt   = r_scored;
      w_dead_cnt_nxt = r_dead_cnt;
      w_enter_dead   = 1'b0;

      // A pipe that jumped rightwards is a new pipe: re-arm scoring
      if (w_frame_tk && w_wrapped) begin
         w_scored_nxt = 1'b0;
      end

      case (r_state)
         S_IDLE: begin
            if (flap) begin
               w_state_nxt = S_PLAY;
               w_score_nxt = 12'h000;
            end
         end
         S_PLAY: begin
            if (w_frame_tk) begin
               if (w_hit) begin
                  // Collision takes priority over a same-frame point
                  w_state_nxt    = S_DEAD;
                  w_enter_dead   = 1'b1;
                  w_dead_cnt_nxt = 6'd0;
               end else if (w_passed && !r_scored) begin
                  w_score_nxt  = w_score_inc;
                  w_scored_nxt = 1'b1;
               end
            end
         end
         S_DEAD: begin
            if (w_frame_tk && (r_dead_cnt < DEAD_FRAMES)) begin
               w_dead_cnt_nxt = r_dead_cnt + 6'd1;
            end
            if (flap && (r_dead_cnt >= DEAD_FRAMES)) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!RESET_N) begin
         r_state     <= S_IDLE;
         r_score     <= 12'h000;
         r_scored    <= 1'b0;
         r_dead_cnt  <= 6'd0;
         r_prev_x    <= 11'd0;
         r_playing   <= 1'b0;
         r_game_over <= 1'b0;
         r_hit_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_score     <= w_score_nxt;
         r_scored    <= w_scored_nxt;
         r_dead_cnt  <= w_dead_cnt_nxt;
         if (w_frame_tk) begin
            r_prev_x <= pipe_x;
         end
         r_playing   <= (w_state_nxt == S_PLAY);
         r_game_over <= (w_state_nxt == S_DEAD);
         r_hit_pulse <= w_enter_dead;
      end
   end

   assign playing   = r_playing;
   assign game_over = r_game_over;
   assign hit_pulse = r_hit_pulse;
   assign score_bcd = r_score;

`ifdef PIPE_COLLISION_HISCORE_EN
   logic [11:0] r_hiscore;

   // BCD digits order the same way as binary, so a plain compare suffices
   always_ff @(posedge clk) begin
      if (!RESET_N) begin
         r_hiscore <= 12'h000;
      end else if (w_enter_dead && (r_score > r_hiscore)) begin
         r_hiscore <= r_score;
      end
   end

   assign hiscore_bcd = r_hiscore;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_collision_score.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_collision_score
//  Purpose  : Directed, table-driven self-checking bench for
//             pipe_collision_score, plus hand sequences for multi-frame cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_collision_score;

   logic        clk = 1'b0;
   logic        RESET_N = 1'b0;
   logic        move = 1'b0;
   logic        flap = 1'b0;
   logic [10:0] bird_y = 11'd280;
   logic [10:0] pipe_x = 11'd300;
   logic [10:0] pipe_y = 11'd300;
   logic        playing;
   logic        game_over;
   logic        hit_pulse;
   logic [11:0] score_bcd;
`ifdef PIPE_COLLISION_HISCORE_EN
   logic [11:0] hiscore_bcd;
`endif

   int checks = 0;
   int errors = 0;
   int hp_count = 0;

   pipe_collision_score dut (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .move      (move),
      .flap      (flap),
      .bird_y    (bird_y),
      .pipe_x    (pipe_x),
      .pipe_y    (pipe_y),
      .playing   (playing),
      .game_over (game_over),
      .hit_pulse (hit_pulse),
      .score_bcd (score_bcd)
`ifdef PIPE_COLLISION_HISCORE_EN
      ,
      .hiscore_bcd (hiscore_bcd)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] by;
      logic [10:0] px;
      logic [10:0] py;
      logic        exp_over;
      logic [11:0] exp_score;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock, then sample 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (hit_pulse === 1'b1) hp_count++;
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      move    = 1'b0;
      flap    = 1'b0;
      tick();
      tick();
      RESET_N = 1'b1;
   endtask

   task automatic press();
      flap = 1'b1;
      tick();
      flap = 1'b0;
   endtask

   // One full move period; frame_tk acts on the third edge after the rise
   task automatic frame();
      move = 1'b1;
      repeat (3) tick();
      move = 1'b0;
      repeat (3) tick();
   endtask

   // A fresh pipe appears to the right, then sits fully left of the bird
   task automatic pass_pipe();
      pipe_x = 11'd300;
      frame();
      pipe_x = 11'd50;
      frame();
   endtask

   function automatic logic [11:0] to_bcd(input int n);
      int v;
      v = (n > 999) ? 999 : n;
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   initial begin
      //           bird_y   pipe_x    pipe_y   over  score
      vecs[0]  = '{11'd280, 11'd300,  11'd300, 1'b0, 12'h000}; // clear of pipe
      vecs[1]  = '{11'd100, 11'd210,  11'd300, 1'b1, 12'h000}; // above gap
      vecs[2]  = '{11'd580, 11'd300,  11'd300, 1'b1, 12'h000}; // floor
      vecs[3]  = '{11'd576, 11'd300,  11'd300, 1'b1, 12'h000}; // floor exact
      vecs[4]  = '{11'd575, 11'd300,  11'd300, 1'b0, 12'h000}; // one above floor
      vecs[5]  = '{11'd100, 11'd232,  11'd300, 1'b0, 12'h000}; // pipe just right
      vecs[6]  = '{11'd100, 11'd231,  11'd300, 1'b1, 12'h000}; // 1 px overlap
      vecs[7]  = '{11'd100, 11'd140,  11'd300, 1'b0, 12'h000}; // pipe just left
      vecs[8]  = '{11'd100, 11'd141,  11'd300, 1'b1, 12'h000}; // 1 px overlap
      vecs[9]  = '{11'd100, 11'd139,  11'd300, 1'b0, 12'h001}; // passed: point
      vecs[10] = '{11'd225, 11'd210,  11'd300, 1'b0, 12'h000}; // at gap top
      vecs[11] = '{11'd224, 11'd210,  11'd300, 1'b1, 12'h000}; // 1 above top
      vecs[12] = '{11'd351, 11'd210,  11'd300, 1'b0, 12'h000}; // at gap bottom
      vecs[13] = '{11'd352, 11'd210,  11'd300, 1'b1, 12'h000}; // 1 below
      vecs[14] = '{11'd0,   11'd210,  11'd50,  1'b0, 12'h000}; // top clamp
      vecs[15] = '{11'd280, 11'd2040, 11'd300, 1'b0, 12'h000}; // no 11b wrap
      vecs[16] = '{11'd580, 11'd50,   11'd300, 1'b1, 12'h000}; // hit beats point

      // Reset state
      do_reset();
      check("reset_playing",   {11'd0, playing},   12'd0);
      check("reset_game_over", {11'd0, game_over}, 12'd0);
      check("reset_hit_pulse", {11'd0, hit_pulse}, 12'd0);
      check("reset_score",     score_bcd,          12'h000);

      // Start of game
      press();
      check("start_playing", {11'd0, playing}, 12'd1);
      check("start_score",   score_bcd,        12'h000);

      // Single-frame geometry table
      for (int i = 0; i < 17; i++) begin
         do_reset();
         check($sformatf("v%0d_rst_over", i), {11'd0, game_over}, 12'd0);
         press();
         bird_y = vecs[i].by;
         pipe_x = vecs[i].px;
         pipe_y = vecs[i].py;
         frame();
         check($sformatf("v%0d_over", i),    {11'd0, game_over}, {11'd0, vecs[i].exp_over});
         check($sformatf("v%0d_playing", i), {11'd0, playing},   {11'd0, ~vecs[i].exp_over});
         check($sformatf("v%0d_score", i),   score_bcd,          vecs[i].exp_score);
      end

      // Pipe sweeping past the bird: exactly one point, no collision
      do_reset();
      press();
      hp_count = 0;
      bird_y = 11'd280;
      pipe_y = 11'd300;
      for (int x = 300; x >= 105; x -= 3) begin
         pipe_x = 11'(x);
         frame();
      end
      check("sweep_score", score_bcd, 12'h001);
      check("sweep_hits",  12'(hp_count), 12'd0);
      check("sweep_playing", {11'd0, playing}, 12'd1);

      // Collision: DEAD, single hit pulse, score held
      bird_y = 11'd100;
      pipe_x = 11'd210;
      frame();
      check("hit_over",  {11'd0, game_over}, 12'd1);
      check("hit_pulse_count", 12'(hp_count), 12'd1);
      check("hit_score", score_bcd, 12'h001);

      // Dead hold: flap ignored until DEAD_FRAMES frames seen
      for (int f = 0; f < 31; f++) frame();
      press();
      check("dead_early_flap", {11'd0, game_over}, 12'd1);
      check("dead_score_hold", score_bcd, 12'h001);
      frame();
      press();
      check("dead_release_over",    {11'd0, game_over}, 12'd0);
      check("dead_release_playing", {11'd0, playing},   12'd0);
      check("idle_score_hold", score_bcd, 12'h001);
      check("dead_hits_total", 12'(hp_count), 12'd1);

      // BCD carries and saturation
      do_reset();
      press();
      bird_y = 11'd280;
      pipe_y = 11'd300;
      pass_pipe();
      frame();            // same pipe, no wrap: no second point
      check("one_per_pass", score_bcd, 12'h001);
      for (int n = 2; n <= 1000; n++) begin
         pass_pipe();
         if (n == 9 || n == 10 || n == 99 || n == 100 || n == 999 || n == 1000)
            check($sformatf("bcd_%0d", n), score_bcd, to_bcd(n));
      end

      // Reset mid-PLAY clears score immediately
      do_reset();
      check("midplay_reset_score",   score_bcd,        12'h000);
      check("midplay_reset_playing", {11'd0, playing}, 12'd0);

`ifdef PIPE_COLLISION_HISCORE_EN
      press();
      bird_y = 11'd280;
      for (int n = 0; n < 5; n++) pass_pipe();
      bird_y = 11'd580;
      frame();
      check("hi_after_5", hiscore_bcd, 12'h005);
      bird_y = 11'd280;
      for (int f = 0; f < 32; f++) frame();
      press();
      press();
      check("hi_game2_score", score_bcd, 12'h000);
      for (int n = 0; n < 3; n++) pass_pipe();
      bird_y = 11'd580;
      frame();
      check("hi_after_3", hiscore_bcd, 12'h005);
      do_reset();
      check("hi_reset", hiscore_bcd, 12'h000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Overall time bound
   initial begin
      #5000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/pipe_collision_score.md
PIPE_COLLISION_SCORE -- requirements
Module: pipe_collision_score

Interface
REQ-001 Parameter BIRD_X, 11'd200, fixed bird left edge (pixels).
REQ-002 Parameter BIRD_W, 11'd32, bird width; BIRD_H, 11'd24, bird height.
REQ-003 Parameter PIPE_W, 11'd60, pipe width; GAP_H, 11'd150, vertical gap height centred on pipe_y.
REQ-004 Parameter FLOOR_Y, 11'd600, ground line; DEAD_FRAMES, 6'd32, frames held in DEAD before restart is accepted.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 RESET_N  input  1  reset, synchronous, active-low.
REQ-007 move  input  1  frame tick from the pipe generator, slower than clk; its 0->1 transition in the clk domain marks one frame.
REQ-008 flap  input  1  player button, level, already debounced.
REQ-009 bird_y  input  11  bird top edge.
REQ-010 pipe_x  input  11  pipe left edge, from pipe generator.
REQ-011 pipe_y  input  11  pipe gap centre, from pipe generator.
REQ-012 playing  output  1  high in state PLAY.
REQ-013 game_over  output  1  high in state DEAD.
REQ-014 hit_pulse  output  1  one-clk pulse on the collision that enters DEAD.
REQ-015 score_bcd  output  12  current score, three BCD digits, [11:8] hundreds.

Function
REQ-016 Block SHALL synchronise move through two flops and generate frame_tk, one clk wide, on each synchronised 0->1 edge; latency is 3 clk from move rising.
REQ-017 FSM states are IDLE, PLAY, DEAD; encoding is free.
REQ-018 IDLE->PLAY when flap=1; score_bcd clears to 0 on the transition.
REQ-019 PLAY->DEAD on a frame_tk where hit=1; hit_pulse asserts in the same edge as the state change.
REQ-020 DEAD->IDLE when flap=1 and at least DEAD_FRAMES frame_tk counted since entering DEAD; flap earlier is ignored.
REQ-021 hit SHALL be evaluated only on frame_tk, in 12-bit arithmetic (no 11-bit wrap): h_ovl = (BIRD_X+BIRD_W > pipe_x) and (BIRD_X < pipe_x+PIPE_W).
REQ-022 v_out = (bird_y < pipe_y-GAP_H/2) or (bird_y+BIRD_H > pipe_y+GAP_H/2); pipe_y-GAP_H/2 below 0 is clamped to 0.
REQ-023 hit = (h_ovl and v_out) or (bird_y+BIRD_H >= FLOOR_Y).
REQ-024 Scoring: on frame_tk in PLAY with hit=0, when pipe_x+PIPE_W < BIRD_X and scored flag is 0, score increments by one and scored sets.
REQ-025 scored clears on frame_tk where pipe_x > previous-frame pipe_x (pipe wrapped); at most one point per pipe pass.
REQ-026 Score increment SHALL be BCD-correct (0x009->0x010, 0x099->0x100) and saturate at 0x999.
REQ-027 Hit and score qualified on the same frame_tk: hit wins, no point awarded.
REQ-028 Outputs are registered; no combinational path from inputs to outputs.
REQ-029 In IDLE and DEAD, score_bcd holds; no increments.

Reset
REQ-030 RESET_N=0 at a clk edge: state IDLE, playing=0, game_over=0, hit_pulse=0, score_bcd=0, scored=0, dead counter=0, sync flops=0.
REQ-031 Reset mid-PLAY or mid-DEAD takes effect at that edge and overrides every other event; first frame_tk needs a fresh move edge after release.

Configuration
REQ-032 Macro PIPE_COLLISION_HISCORE_EN defined: adds output hiscore_bcd (12 bits) updated to score_bcd on PLAY->DEAD when score_bcd > hiscore_bcd; cleared only by RESET_N.
REQ-033 Macro undefined: no hiscore_bcd port or register; all other behaviour identical.

Verification
REQ-034 Reset, flap=1 -> playing=1 after one clk, score_bcd=0x000.
REQ-035 PLAY, bird_y=280, pipe_y=300, pipe_x 300 stepping -3 per move edge to 105 -> exactly one point, score_bcd=0x001, hit_pulse never.
REQ-036 PLAY, bird_y=100, pipe_y=300, pipe_x=210 -> on next frame_tk game_over=1, hit_pulse one clk, score held.
REQ-037 PLAY, bird_y=580 -> DEAD on next frame_tk; flap before 32 frames ignored, flap after frame 32 -> IDLE.
REQ-038 Preload score 0x099 via passes, pass one more pipe -> 0x100; at 0x999 another pass -> 0x999.
REQ-039 With PIPE_COLLISION_HISCORE_EN: game scoring 5 then game scoring 3 -> hiscore_bcd=0x005; RESET_N=0 -> 0x000.
